// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches framebuffer rows into a double-buffered line buffer and serves pixels by x/y.
// Define VGA_LINE_FETCH_PIX_DOUBLE_EN for a half-resolution framebuffer with 2x pixel/line doubling.
module vga_line_fetch #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int HSS = 143,
  parameter int VSS = 35,
  parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pix_data,
  output logic        underrun
);
`ifdef VGA_LINE_FETCH_PIX_DOUBLE_EN
  localparam int NW = HACTIVE / 2;
  localparam int SH = 1;
`else
  localparam int NW = HACTIVE;
  localparam int SH = 0;
`endif
  localparam int AW = $clog2(NW);
  localparam logic [31:0] STRIDE = 32'(NW * 4);
  localparam logic [9:0] Y0 = 10'(VSS - 1);
  localparam logic [9:0] Y1 = 10'(VSS + VACTIVE - 2);
  localparam logic [9:0] V0 = 10'(VSS);
  localparam logic [9:0] V1 = 10'(VSS + VACTIVE - 1);
  localparam logic [9:0] X0 = 10'(HSS - 1);
  localparam logic [9:0] X1 = 10'(HSS + HACTIVE - 2);
  localparam logic [9:0] LAST = 10'(NW - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state, state_n;
  logic [9:0] col;
  logic [AW-1:0] rx;
  logic [31:0] row_base, start;
  logic [1:0] full, full_n;
  logic disp, win, trig, sw, swap, ack;
  logic [31:0] lb [2][NW];
  assign win = x == '0 && y >= Y0 && y <= Y1;
`ifdef VGA_LINE_FETCH_PIX_DOUBLE_EN
  // fetch ahead of even display lines, swap in at the first line of each row pair
  assign trig = win && !(y[0] ^ Y0[0]);
  assign sw = win && (y[0] ^ Y0[0]);
`else
  assign trig = win;
  assign sw = win;
`endif
  assign swap = sw && (full[~disp] || state == DONE);
  assign ack = state == FETCH && mem_ack;
  assign mem_req = state == FETCH;
  assign start = y == Y0 ? FB_BASE : row_base + STRIDE;
  assign rx = AW'((x - X0) >> SH);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = trig ? FETCH : state == FETCH ? (mem_ack && col == LAST ? DONE : FETCH) : IDLE;
    full_n = full;
    if (state == DONE) full_n[~disp] = 1'b1;
    if (swap) full_n[disp] = 1'b0;
    else if (trig) full_n[~disp] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      disp <= 1'b0;
      full <= '0;
      col <= '0;
      mem_addr <= '0;
      row_base <= FB_BASE;
      underrun <= 1'b0;
      pix_data <= '0;
    end else begin
      full <= full_n;
      if (swap) disp <= ~disp;
      if (trig) begin
        col <= '0;
        mem_addr <= start;
        row_base <= start;
      end else if (ack) begin
        col <= col + 10'd1;
        mem_addr <= mem_addr + 32'd4;
      end
      if (trig && state == FETCH) underrun <= 1'b1;
      pix_data <= (x >= X0 && x <= X1 && y >= V0 && y <= V1 && full[disp]) ? lb[disp][rx] : '0;
    end
  always_ff @(posedge clk)
    if (ack) lb[~disp][col[AW-1:0]] <= mem_rdata;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: raster-driven random bench with a row-level reference model of fetch and display.
module tb_vga_line_fetch;
  localparam int HA = 640, HS = 143, VS = 35, HMAX = 800;
  localparam logic [31:0] BASE = 32'h0004_0000;
  logic clk = 0, rst = 0, mem_req, mem_ack = 0, underrun;
  logic [9:0] x = 0, y = 0;
  logic [31:0] mem_addr, mem_rdata = 0, pix_data;
  int n_chk = 0, n_fail = 0;
  int disp_row = -1, cur_row = 0, rem = 0;
  bit pend = 0, exp_ur = 0, tgl = 0;
  logic [31:0] exp_pix, seed;

  vga_line_fetch #(.FB_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pix_data(pix_data), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] rowaddr(int r);
    return BASE + 32'(r * HA * 4);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s x=%0d y=%0d: got %h expected %h", tag, x, y, got, exp);
    end
  endtask

  task automatic cyc(int mode);
    logic [9:0] ax, ay;
    bit aa, trig;
    ax = x; ay = y; aa = mem_ack;
    @(posedge clk); #1;
    exp_pix = (ax >= HS - 1 && ax <= HS + HA - 2 && ay >= VS && ay <= VS + 479 && disp_row >= 0)
              ? f(rowaddr(disp_row) + 32'((ax - (HS - 1)) * 4)) : 32'h0;
    trig = ax == 0 && ay >= VS - 1 && ay <= VS + 478;
    if (trig) begin
      if (rem > 0) exp_ur = 1;
      else if (pend) disp_row = cur_row;
      cur_row = ay - (VS - 1);
      rem = HA;
      pend = 0;
    end else if (aa && rem > 0) begin
      rem--;
      if (rem == 0) pend = 1;
    end
    chk("mem_req", mem_req, rem > 0);
    if (rem > 0) chk("mem_addr", mem_addr, rowaddr(cur_row) + 32'((HA - rem) * 4));
    chk("underrun", underrun, exp_ur);
    if ($urandom % 8 == 0 || ax inside {141, 142, 147, 780, 781, 782})
      chk("pix", pix_data, exp_pix);
    x = (ax == HMAX - 1) ? 10'd0 : ax + 10'd1;
    y = (ax == HMAX - 1) ? ay + 10'd1 : ay;
    tgl = ~tgl;
    mem_ack = rem > 0 && (mode == 0 || (mode == 1 && tgl) || (mode == 2 && $urandom % 8 != 0));
    mem_rdata = mem_ack ? f(mem_addr) : $urandom;
  endtask

  task automatic run(int lines, int mode);
    repeat (lines * HMAX) cyc(mode);
  endtask

  initial begin
    seed = $urandom;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      x = 10'($urandom % 800);
      y = 10'($urandom % 525);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pix", pix_data, 0);
      chk("rst_ur", underrun, 0);
    end
    @(posedge clk); #1;
    x = 0; y = 32; rst = 1;
    run(6, 0);
    run(4, 2);
    for (int i = 0; i < HMAX && rem != HA - 100; i++) cyc(0);
    chk("midfetch_col", rem, HA - 100);
    #3 rst = 0;
    #1 chk("async_req", mem_req, 0);
    chk("async_ur", underrun, 0);
    disp_row = -1; rem = 0; pend = 0; exp_ur = 0;
    mem_ack = 0;
    repeat (3) @(posedge clk);
    #1 chk("hold_pix", pix_data, 0);
    chk("hold_req", mem_req, 0);
    x = 0; y = 33; rst = 1;
    run(5, 1);
    run(3, 0);
    run(2, 2);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
